// File: rtl/des_result_uart_tx.sv
// rtl/des_result_uart_tx.sv - 8N1 UART transmitter for the 64-bit 3DES result block.
// Optional DES_TX_HEX_ASCII_EN: send 16 uppercase ASCII hex characters plus CR/LF instead of 8 raw bytes.
module des_result_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:64] data_in,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LP_CNT_MAX = CW'(CLKS_PER_BIT - 1);
`ifdef DES_TX_HEX_ASCII_EN
  localparam logic [4:0] LP_LAST_CHAR = 5'd17;
`else
  localparam logic [4:0] LP_LAST_CHAR = 5'd7;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_clk_cnt;
  logic [2:0]      r_bit_idx;
  logic [4:0]      r_char_idx;
  logic [63:0]     r_shift;
  logic            r_tx;
  logic            r_busy;
  logic            r_done;
  logic            w_tx_nxt;
  logic            w_busy_nxt;
  logic            w_done_nxt;
  logic            w_load;
  logic            w_next_char;
  logic            w_bit_end;
  logic [7:0]      w_char;

  assign w_bit_end = (r_clk_cnt == LP_CNT_MAX);

`ifdef DES_TX_HEX_ASCII_EN
  logic [3:0] w_nibble;

  // Nibbles are consumed from the top of the shift register; characters 16/17 are the CR/LF trailer.
  always_comb begin
    w_nibble = r_shift[63:60];
    if (r_char_idx == 5'd16) begin
      w_char = 8'h0D;
    end else if (r_char_idx == 5'd17) begin
      w_char = 8'h0A;
    end else if (w_nibble < 4'd10) begin
      w_char = {4'h3, w_nibble};
    end else begin
      w_char = 8'h37 + {4'h0, w_nibble};
    end
  end
`else
  assign w_char = r_shift[63:56];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Outputs are computed for the next state so tx/busy/done come straight from flops.
  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = 1'b1;
    w_busy_nxt  = 1'b1;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_next_char = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy_nxt = 1'b0;
        if (start) begin
          w_state_nxt = START;
          w_tx_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
          w_load      = 1'b1;
        end
      end
      START: begin
        w_tx_nxt = 1'b0;
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_tx_nxt    = w_char[0];
        end
      end
      DATA: begin
        w_tx_nxt = w_char[r_bit_idx];
        if (w_bit_end) begin
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_tx_nxt = w_char[r_bit_idx + 3'd1];
          end
        end
      end
      STOP: begin
        if (w_bit_end) begin
          if (r_char_idx == LP_LAST_CHAR) begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = START;
            w_tx_nxt    = 1'b0;
            w_next_char = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_cnt  <= '0;
      r_bit_idx  <= 3'd0;
      r_char_idx <= 5'd0;
      r_shift    <= 64'd0;
    end else begin
      if (r_state == IDLE || w_bit_end) begin
        r_clk_cnt <= '0;
      end else begin
        r_clk_cnt <= r_clk_cnt + 1'b1;
      end

      if (w_load) begin
        r_bit_idx <= 3'd0;
      end else if (r_state == DATA && w_bit_end) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end

      if (w_load) begin
        r_char_idx <= 5'd0;
        r_shift    <= data_in;
      end else if (w_next_char) begin
        r_char_idx <= r_char_idx + 5'd1;
`ifdef DES_TX_HEX_ASCII_EN
        r_shift    <= {r_shift[59:0], 4'h0};
`else
        r_shift    <= {r_shift[55:0], 8'h00};
`endif
      end
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;

endmodule
